// File: rtl/cvp14_mem_responder.sv
// CVP14 system-memory responder: sequential preload, 1-cycle reads, sticky errors, counters.
// Optional write protection of the low program region when CVP_MEM_WPROT_EN is defined.
module cvp14_mem_responder #(
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WP_LIMIT = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_data_in,
    output logic [15:0] o_data_out,
    input  logic        i_ld_valid,
    input  logic [15:0] i_ld_data,
    input  logic        i_ld_last,
    output logic        o_busy,
    output logic        o_ld_ovf,
    output logic        o_bus_err,
    output logic [15:0] o_rd_count,
    output logic [15:0] o_wr_count
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef enum logic [0:0] {StLoad, StServe} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [15:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ldptr;
    logic [15:0]       r_data_out;
    logic              r_ld_ovf;
    logic              r_bus_err;
    logic [15:0]       r_rd_count;
    logic [15:0]       r_wr_count;

    logic              w_in_range;
    logic              w_wprot;
    logic              w_ld_ovf_hit;
    logic              w_ld_step;
    logic              w_sv_rd;
    logic              w_sv_wr;
    logic              w_rd_oor;
    logic              w_err;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [15:0]       w_mem_wdata;

    assign w_in_range = 32'(i_addr) < DEPTH;

`ifdef CVP_MEM_WPROT_EN
    assign w_wprot = 32'(i_addr) < WP_LIMIT;
`else
    // Protection compiled out; WP_LIMIT stays referenced so the interface is identical.
    assign w_wprot = (WP_LIMIT != WP_LIMIT);
`endif

    // Last array slot written without LdLast: stop loading rather than wrap.
    assign w_ld_ovf_hit = i_ld_valid && !i_ld_last && (r_ldptr == PTR_W'(DEPTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:  if (i_ld_last || w_ld_ovf_hit) w_state_next = StServe;
            StServe: w_state_next = StServe;
            default: w_state_next = StLoad;
        endcase
    end

    always_comb begin
        o_busy      = 1'b0;
        w_ld_step   = 1'b0;
        w_sv_rd     = 1'b0;
        w_sv_wr     = 1'b0;
        w_rd_oor    = 1'b0;
        w_err       = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = i_addr[ADDR_W-1:0];
        w_mem_wdata = i_data_in;
        unique case (r_state)
            StLoad: begin
                o_busy      = 1'b1;
                w_ld_step   = i_ld_valid && (r_ldptr < PTR_W'(DEPTH));
                w_mem_we    = w_ld_step;
                w_mem_waddr = r_ldptr[ADDR_W-1:0];
                w_mem_wdata = i_ld_data;
            end
            StServe: begin
                w_sv_rd  = i_rd && w_in_range;
                w_sv_wr  = i_wr && w_in_range && !w_wprot;
                w_rd_oor = i_rd && !w_in_range;
                w_mem_we = w_sv_wr;
                w_err    = (i_rd && i_wr) || ((i_rd || i_wr) && !w_in_range)
                           || (i_wr && w_in_range && w_wprot);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    // Non-blocking read alongside the write gives read-before-write on collisions.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ldptr    <= '0;
            r_data_out <= 16'h0000;
            r_ld_ovf   <= 1'b0;
            r_bus_err  <= 1'b0;
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
        end else begin
            if (w_ld_step) r_ldptr <= r_ldptr + 1'b1;
            if (r_state == StLoad && w_ld_ovf_hit) r_ld_ovf <= 1'b1;
            if (w_sv_rd) begin
                r_data_out <= r_mem[i_addr[ADDR_W-1:0]];
            end else if (w_rd_oor) begin
                r_data_out <= 16'h0000;
            end
            if (w_sv_rd && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            if (w_sv_wr && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            if (w_err) r_bus_err <= 1'b1;
        end
    end

    assign o_data_out = r_data_out;
    assign o_ld_ovf   = r_ld_ovf;
    assign o_bus_err  = r_bus_err;
    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Scoreboard bench for cvp14_mem_responder; a second small instance covers preload overflow.
module tb_cvp14_mem_responder;

    localparam int unsigned DEPTH = 4096;
`ifdef CVP_MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset, i_rd, i_wr, i_ld_valid, i_ld_last;
    logic [15:0] i_addr, i_din, i_ld_data;
    logic [15:0] o_dout, o_rd_count, o_wr_count;
    logic        o_busy, o_ld_ovf, o_bus_err;

    logic        s_rd, s_ld_valid;
    logic [15:0] s_addr, s_ld_data;
    logic [15:0] s_dout, s_rd_count, s_wr_count;
    logic        s_busy, s_ld_ovf, s_bus_err;

    always #5 clk = ~clk;

    cvp14_mem_responder u_dut (
        .i_clk(clk), .i_reset(i_reset), .i_addr(i_addr), .i_rd(i_rd), .i_wr(i_wr),
        .i_data_in(i_din), .o_data_out(o_dout), .i_ld_valid(i_ld_valid),
        .i_ld_data(i_ld_data), .i_ld_last(i_ld_last), .o_busy(o_busy),
        .o_ld_ovf(o_ld_ovf), .o_bus_err(o_bus_err), .o_rd_count(o_rd_count),
        .o_wr_count(o_wr_count)
    );

    cvp14_mem_responder #(.DEPTH(8), .ADDR_W(3), .WP_LIMIT(2)) u_small (
        .i_clk(clk), .i_reset(i_reset), .i_addr(s_addr), .i_rd(s_rd), .i_wr(1'b0),
        .i_data_in(16'h0000), .o_data_out(s_dout), .i_ld_valid(s_ld_valid),
        .i_ld_data(s_ld_data), .i_ld_last(1'b0), .o_busy(s_busy),
        .o_ld_ovf(s_ld_ovf), .o_bus_err(s_bus_err), .o_rd_count(s_rd_count),
        .o_wr_count(s_wr_count)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_mem[int];
    logic [15:0] m_last;
    int          m_rd, m_wr;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 1'b0; m_last = 16'h0000;
        chk("rst_dout", o_dout, 16'h0000);
        chk("rst_busy", o_busy, 1'b1);
        chk("rst_ovf", o_ld_ovf, 1'b0);
        chk("rst_err", o_bus_err, 1'b0);
        chk("rst_rdcnt", o_rd_count, 16'h0000);
        chk("rst_wrcnt", o_wr_count, 16'h0000);
    endtask

    task automatic ld_beat(input logic valid, input logic [15:0] data, input logic last);
        i_ld_valid = valid; i_ld_data = data; i_ld_last = last;
        step();
        i_ld_valid = 1'b0; i_ld_last = 1'b0;
    endtask

    task automatic serve_req(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] din);
        logic inr, prot;
        i_rd = rd; i_wr = wr; i_addr = addr; i_din = din;
        inr  = 32'(addr) < DEPTH;
        prot = WPROT && (addr < 16'd256);
        if (rd) exp_q.push_back(inr ? m_mem[int'(addr)] : 16'h0000);
        if (rd && inr) m_rd++;
        if (wr && inr && !prot) begin
            m_mem[int'(addr)] = din;
            m_wr++;
        end
        if ((rd && wr) || ((rd || wr) && !inr) || (wr && inr && prot)) m_err = 1'b1;
        step();
        i_rd = 1'b0; i_wr = 1'b0;
        if (rd) m_last = exp_q.pop_front();
        chk($sformatf("dout@%0h", addr), o_dout, m_last);
        chk("rdcnt", o_rd_count, m_rd[15:0]);
        chk("wrcnt", o_wr_count, m_wr[15:0]);
        chk("buserr", o_bus_err, m_err);
    endtask

    initial begin
        i_reset = 1'b0; i_rd = 1'b0; i_wr = 1'b0; i_addr = 16'h0; i_din = 16'h0;
        i_ld_valid = 1'b0; i_ld_data = 16'h0; i_ld_last = 1'b0;
        s_rd = 1'b0; s_addr = 16'h0; s_ld_valid = 1'b0; s_ld_data = 16'h0;
        do_reset();
        chk("s_rst_busy", s_busy, 1'b1);

        // Small instance: 8 words, no LdLast -> overflow, no wrap.
        for (int i = 0; i < 8; i++) begin
            s_ld_valid = 1'b1; s_ld_data = 16'hA0 + 16'(i);
            step();
            if (i == 6) begin
                chk("s_ovf_early", s_ld_ovf, 1'b0);
                chk("s_busy_early", s_busy, 1'b1);
            end
        end
        s_ld_valid = 1'b0;
        chk("s_ovf", s_ld_ovf, 1'b1);
        chk("s_busy", s_busy, 1'b0);
        s_rd = 1'b1; s_addr = 16'd7; step();
        chk("s_rd7", s_dout, 16'h00A7);
        s_addr = 16'd0; step(); s_rd = 1'b0;
        chk("s_rd0", s_dout, 16'h00A0);

        // Preload; a read presented on the LdLast beat must be ignored.
        for (int i = 0; i < 3; i++) begin
            ld_beat(1'b1, 16'h1000 + 16'(i), 1'b0);
            m_mem[i] = 16'h1000 + 16'(i);
        end
        chk("busy_mid", o_busy, 1'b1);
        i_rd = 1'b1; i_addr = 16'd1;
        ld_beat(1'b1, 16'h1003, 1'b1);
        i_rd = 1'b0;
        m_mem[3] = 16'h1003;
        chk("busy_fall", o_busy, 1'b0);
        chk("ignored_rd_dout", o_dout, 16'h0000);
        chk("ignored_rd_cnt", o_rd_count, 16'h0000);

        for (int i = 0; i < 4; i++) serve_req(1'b1, 1'b0, 16'(i), 16'h0);
        step();
        chk("hold_idle", o_dout, m_last);

        serve_req(1'b0, 1'b1, 16'd300, 16'hBEEF);
        serve_req(1'b1, 1'b0, 16'd300, 16'h0);

        // Low region: dropped with an error only when protection is built in.
        serve_req(1'b0, 1'b1, 16'd5, 16'hFFFF);
        serve_req(1'b0, 1'b1, 16'd3, 16'hFFFF);
        serve_req(1'b1, 1'b0, 16'd3, 16'h0);

        // Mid-run reset keeps the image; LdLast alone returns to SERVE.
        do_reset();
        ld_beat(1'b0, 16'h0, 1'b1);
        chk("busy_reload", o_busy, 1'b0);
        serve_req(1'b1, 1'b0, 16'd300, 16'h0);
        serve_req(1'b1, 1'b0, 16'd0, 16'h0);

        serve_req(1'b1, 1'b0, 16'h2000, 16'h0);
        serve_req(1'b0, 1'b1, 16'h2000, 16'h1234);

        do_reset();
        ld_beat(1'b0, 16'h0, 1'b1);
        serve_req(1'b0, 1'b1, 16'd400, 16'h0001);
        serve_req(1'b1, 1'b1, 16'd400, 16'h0002);
        serve_req(1'b1, 1'b0, 16'd400, 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
